uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_parser_pkg.sv | 28 ++
 rtl/uart_cmd_parser_if.sv | 44 ++++
 rtl/uart_cmd_parser_hex_nibble_decode.sv | 26 ++
 rtl/uart_cmd_parser.sv | 208 ++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and types for the UART command parser (package charmatrix_pkg).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package charmatrix_pkg;

    localparam int MAX_CHARS_DEFAULT = 8;

    // ASCII control and printable-range bounds
    localparam logic [7:0] CH_ESC      = 8'h1B;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    // Command letters that may follow ESC
    localparam logic [7:0] CMD_COLOR = 8'h43;  // 'C'
    localparam logic [7:0] CMD_RAND  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_HOME  = 8'h48;  // 'H'
    localparam logic [7:0] CMD_CLEAR = 8'h58;  // 'X'

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ESC       = 2'd1,
        COLOR_ARG = 2'd2,
        CLEAR     = 2'd3
    } state_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream in, text-buffer write strobe out, optional echo (UART_CMD_PARSER_ECHO_EN).
// Latency: n/a (signal bundle only).
// Backpressure: rx_valid/rx_ready handshake; echo uses tx_valid/tx_ready.
interface uart_cmd_parser_if #(
    parameter int MAX_CHARS = 8
);
    localparam int AW = $clog2(MAX_CHARS);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_char;
    logic [3:0]    wr_color;
`ifdef UART_CMD_PARSER_ECHO_EN
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    // Parser side
    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, wr_en, wr_addr, wr_char, wr_color, tx_data, tx_valid
    );
    // UART / buffer side
    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, wr_en, wr_addr, wr_char, wr_color, tx_data, tx_valid
    );
`else
    // Parser side
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_char, wr_color
    );
    // UART / buffer side
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_char, wr_color
    );
`endif

endinterface

// File: rtl/uart_cmd_parser_hex_nibble_decode.sv
// Decodes an ASCII hex digit ('0'-'9', 'A'-'F', 'a'-'f') to its 4-bit value.
// Latency: combinational.
// Backpressure: none.
module hex_nibble_decode (
    input  logic [7:0] ch,
    output logic [3:0] value,
    output logic       valid
);

    // Range-check the byte and subtract the matching ASCII offset
    always_comb begin
        value = 4'd0;
        valid = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            value = 4'(ch - 8'h30);
            valid = 1'b1;
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            value = 4'(ch - 8'h37);
            valid = 1'b1;
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            value = 4'(ch - 8'h57);
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Terminal-style parser: printable bytes -> buffer writes, ESC C/R/H/X commands; echo via UART_CMD_PARSER_ECHO_EN.
// Latency: every output registered, write/cmd_error 1 cycle after byte acceptance; CLEAR = MAX_CHARS write cycles.
// Backpressure: rx_ready drops for the cycle after each accept, for all of CLEAR, and while an echo is pending.
module uart_cmd_parser
    import charmatrix_pkg::*;
#(
    parameter int         MAX_CHARS     = MAX_CHARS_DEFAULT,
    parameter logic [3:0] DEFAULT_COLOR = 4'd0
) (
    input  logic                         clk,
    input  logic                         reset,
    uart_cmd_parser_if.slave             bus,
    input  logic [$clog2(MAX_CHARS)-1:0] max_index,
    input  logic [3:0]                   rnd_color,
    output logic [$clog2(MAX_CHARS)-1:0] cursor,
    output logic                         busy,
    output logic                         cmd_error
);

    localparam int            AW       = $clog2(MAX_CHARS);
    localparam logic [AW-1:0] LAST_IDX = AW'(MAX_CHARS - 1);

    state_t        state_q, state_n;
    logic [3:0]    color_q, color_n;
    logic          rand_q, rand_n;
    logic [AW-1:0] cursor_q, cursor_n;
    logic [AW-1:0] clr_q, clr_n;
    logic          wr_en_q, wr_en_n;
    logic [AW-1:0] wr_addr_q, wr_addr_n;
    logic [7:0]    wr_char_q, wr_char_n;
    logic [3:0]    wr_color_q, wr_color_n;
    logic          busy_q, busy_n;
    logic          err_q, err_n;
    logic          rdy_q, rdy_n;
    logic          accept;
    logic          echo_pending_n;
    logic [3:0]    hex_val;
    logic          hex_vld;
`ifdef UART_CMD_PARSER_ECHO_EN
    logic [7:0]    tx_data_q, tx_data_n;
    logic          tx_valid_q, tx_valid_n;
`endif

    hex_nibble_decode u_hex (
        .ch    (bus.rx_data),
        .value (hex_val),
        .valid (hex_vld)
    );

    // Next write position; a shrunken max_index forces a wrap to 0
    function automatic logic [AW-1:0] advance(input logic [AW-1:0] pos, input logic [AW-1:0] lim);
        return (pos >= lim) ? '0 : pos + AW'(1);
    endfunction

    // Next-state, datapath and registered-output values
    always_comb begin
        state_n    = state_q;
        color_n    = color_q;
        rand_n     = rand_q;
        cursor_n   = cursor_q;
        clr_n      = clr_q;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr_q;
        wr_char_n  = wr_char_q;
        wr_color_n = wr_color_q;
        err_n      = 1'b0;
        accept     = bus.rx_valid & rdy_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.rx_data >= CH_PRINT_LO && bus.rx_data <= CH_PRINT_HI) begin
                        wr_en_n    = 1'b1;
                        wr_addr_n  = cursor_q;
                        wr_char_n  = bus.rx_data;
                        wr_color_n = rand_q ? rnd_color : color_q;
                        cursor_n   = advance(cursor_q, max_index);
                    end else if (bus.rx_data == CH_CR) begin
                        cursor_n = '0;
                    end else if (bus.rx_data == CH_BS) begin
                        cursor_n = (cursor_q == '0) ? max_index : cursor_q - AW'(1);
                    end else if (bus.rx_data == CH_ESC) begin
                        state_n = ESC;
                    end
                end
            end
            ESC: begin
                if (accept) begin
                    state_n = IDLE;
                    case (bus.rx_data)
                        CMD_COLOR: state_n = COLOR_ARG;
                        CMD_RAND:  rand_n = 1'b1;
                        CMD_HOME: begin
                            cursor_n = '0;
                            color_n  = DEFAULT_COLOR;
                            rand_n   = 1'b0;
                        end
                        CMD_CLEAR: begin
                            state_n = CLEAR;
                            clr_n   = '0;
                        end
                        CH_ESC:    state_n = ESC;
                        default:   err_n = 1'b1;
                    endcase
                end
            end
            COLOR_ARG: begin
                if (accept) begin
                    state_n = IDLE;
                    if (hex_vld) begin
                        color_n = hex_val;
                        rand_n  = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            CLEAR: begin
                wr_en_n    = 1'b1;
                wr_addr_n  = clr_q;
                wr_char_n  = 8'h00;
                wr_color_n = 4'd0;
                if (clr_q == LAST_IDX) begin
                    state_n  = IDLE;
                    cursor_n = '0;
                    clr_n    = '0;
                end else begin
                    clr_n = clr_q + AW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef UART_CMD_PARSER_ECHO_EN
        tx_data_n  = tx_data_q;
        tx_valid_n = tx_valid_q;
        if (accept) begin
            tx_data_n  = bus.rx_data;
            tx_valid_n = 1'b1;
        end else if (tx_valid_q && bus.tx_ready) begin
            tx_valid_n = 1'b0;
        end
        echo_pending_n = tx_valid_n;
`else
        echo_pending_n = 1'b0;
`endif

        busy_n = (state_n == CLEAR);
        rdy_n  = (state_n != CLEAR) && !accept && !echo_pending_n;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            color_q    <= DEFAULT_COLOR;
            rand_q     <= 1'b0;
            cursor_q   <= '0;
            clr_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_char_q  <= 8'h00;
            wr_color_q <= 4'd0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            color_q    <= color_n;
            rand_q     <= rand_n;
            cursor_q   <= cursor_n;
            clr_q      <= clr_n;
            wr_en_q    <= wr_en_n;
            wr_addr_q  <= wr_addr_n;
            wr_char_q  <= wr_char_n;
            wr_color_q <= wr_color_n;
            busy_q     <= busy_n;
            err_q      <= err_n;
            rdy_q      <= rdy_n;
        end
    end

`ifdef UART_CMD_PARSER_ECHO_EN
    // Echo holding register, cleared once the transmitter takes the byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            tx_data_q  <= tx_data_n;
            tx_valid_q <= tx_valid_n;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
`endif

    assign bus.rx_ready = rdy_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_char  = wr_char_q;
    assign bus.wr_color = wr_color_q;
    assign cursor       = cursor_q;
    assign busy         = busy_q;
    assign cmd_error    = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboarded bench for uart_cmd_parser; echo checks included when UART_CMD_PARSER_ECHO_EN is defined.
// Latency: expected writes queued at send time, compared when wr_en is seen.
// Backpressure: driver holds rx_valid until rx_ready, bounded by a cycle budget.
module tb_uart_cmd_parser;

    localparam int MC = 8;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] ch;
        logic [3:0] color;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] max_index = 3'd3;
    logic [3:0] rnd_color = 4'd0;
    logic [2:0] cursor;
    logic       busy;
    logic       cmd_error;

    int n_cmp = 0;
    int n_err = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int bad_rdy = 0;
    wr_t sb[$];

    uart_cmd_parser_if #(.MAX_CHARS(MC)) bus ();

    uart_cmd_parser #(.MAX_CHARS(MC), .DEFAULT_COLOR(4'd0)) dut (
        .clk       (clk),
        .reset     (rst),
        .bus       (bus),
        .max_index (max_index),
        .rnd_color (rnd_color),
        .cursor    (cursor),
        .busy      (busy),
        .cmd_error (cmd_error)
    );

    always #25 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_wr(input logic [2:0] a, input logic [7:0] c, input logic [3:0] k);
        wr_t w;
        w.addr = a;
        w.ch = c;
        w.color = k;
        sb.push_back(w);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_val("rdy_timeout", n, 0);
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard compare plus pulse / busy bookkeeping
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en) begin
                check_val("wr_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    check_val("wr_addr", bus.wr_addr, e.addr);
                    check_val("wr_char", bus.wr_char, e.ch);
                    check_val("wr_color", bus.wr_color, e.color);
                end
            end
            if (cmd_error) err_cnt++;
            if (busy) busy_cnt++;
            if (busy && bus.rx_ready) bad_rdy++;
        end
    end

    initial begin
        int e0, b0;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
`ifdef UART_CMD_PARSER_ECHO_EN
        bus.tx_ready = 1'b1;
`endif
        idle(3);
        check_val("rst_rx_ready", bus.rx_ready, 0);
        check_val("rst_wr_en", bus.wr_en, 0);
        check_val("rst_wr_addr", bus.wr_addr, 0);
        check_val("rst_wr_char", bus.wr_char, 0);
        check_val("rst_wr_color", bus.wr_color, 0);
        check_val("rst_cursor", cursor, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_cmd_error", cmd_error, 0);
        rst = 1'b0;
        idle(2);
        check_val("ready_after_rst", bus.rx_ready, 1);

        // Wrap at max_index=3
        exp_wr(0, "A", 0); exp_wr(1, "B", 0); exp_wr(2, "C", 0);
        exp_wr(3, "D", 0); exp_wr(0, "E", 0);
        send_byte("A"); send_byte("B"); send_byte("C"); send_byte("D"); send_byte("E");
        idle(2);
        check_val("cursor_wrap", cursor, 1);

        // Colour argument, then a bad argument keeps colour
        send_byte(8'h1B); send_byte("C"); send_byte("a");
        exp_wr(1, "Z", 10);
        send_byte("Z");
        e0 = err_cnt;
        send_byte(8'h1B); send_byte("C"); send_byte("g");
        idle(2);
        check_val("bad_hex_err", err_cnt - e0, 1);
        exp_wr(2, "Y", 10);
        send_byte("Y");

        // Random mode, unknown command, home
        rnd_color = 4'd7;
        send_byte(8'h1B); send_byte("R");
        exp_wr(3, "Q", 7);
        send_byte("Q");
        e0 = err_cnt;
        send_byte(8'h1B); send_byte("?");
        idle(2);
        check_val("bad_cmd_err", err_cnt - e0, 1);
        send_byte(8'h1B); send_byte("H");
        exp_wr(0, "Q", 0);
        send_byte("Q");
        idle(1);
        check_val("cursor_after_home", cursor, 1);

        // CR, backspace wrap from 0, CR without write
        send_byte(8'h0D);
        idle(1);
        check_val("cursor_cr", cursor, 0);
        max_index = 3'd7;
        send_byte(8'h08);
        idle(1);
        check_val("cursor_bs_wrap", cursor, 7);
        exp_wr(7, "x", 0);
        send_byte("x");
        idle(1);
        check_val("cursor_after_x", cursor, 0);
        send_byte(8'h0D);
        idle(2);
        check_val("cursor_cr2", cursor, 0);

        // max_index shrinks below cursor: next advance wraps to 0
        exp_wr(0, "a", 0); exp_wr(1, "b", 0); exp_wr(2, "c", 0);
        exp_wr(3, "d", 0); exp_wr(4, "e", 0);
        send_byte("a"); send_byte("b"); send_byte("c"); send_byte("d"); send_byte("e");
        max_index = 3'd2;
        exp_wr(5, "f", 0);
        send_byte("f");
        idle(1);
        check_val("cursor_shrink", cursor, 0);

        // ESC ESC keeps waiting for a command
        send_byte(8'h1B); send_byte(8'h1B); send_byte("C"); send_byte("3");
        exp_wr(0, "k", 3);
        send_byte("k");
        send_byte(8'h1B); send_byte("H");
        max_index = 3'd7;

        // Full clear with the next byte already pending
        b0 = busy_cnt;
        send_byte(8'h1B);
        for (int i = 0; i < MC; i++) exp_wr(3'(i), 8'h00, 0);
        exp_wr(0, "A", 0);
        send_byte("X");
        send_byte("A");
        idle(2);
        check_val("busy_cycles", busy_cnt - b0, MC);
        check_val("rdy_during_busy", bad_rdy, 0);
        check_val("cursor_after_clear", cursor, 1);

        // Reset in the middle of a clear
        send_byte(8'h1B); send_byte("C"); send_byte("5");
        send_byte(8'h1B);
        exp_wr(0, 8'h00, 0); exp_wr(1, 8'h00, 0); exp_wr(2, 8'h00, 0);
        send_byte("X");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("mid_clr_wr_en", bus.wr_en, 0);
        check_val("mid_clr_busy", busy, 0);
        check_val("mid_clr_rdy", bus.rx_ready, 0);
        check_val("mid_clr_cursor", cursor, 0);
        check_val("mid_clr_sb", sb.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_wr(0, "M", 0);
        send_byte("M");
        idle(2);

`ifdef UART_CMD_PARSER_ECHO_EN
        // Echo stall holds off the receiver
        bus.tx_ready = 1'b0;
        exp_wr(1, "e", 0);
        send_byte("e");
        idle(5);
        check_val("echo_rdy_held", bus.rx_ready, 0);
        check_val("echo_valid", bus.tx_valid, 1);
        check_val("echo_data", bus.tx_data, 8'h65);
        bus.tx_ready = 1'b1;
        idle(1);
        check_val("echo_valid_clr", bus.tx_valid, 0);
        check_val("echo_rdy_back", bus.rx_ready, 1);
`endif

        idle(4);
        check_val("sb_empty", sb.size(), 0);
        check_val("err_total", err_cnt, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
